// File: rtl/lsu_dccm_arb.sv
// DCCM port arbiter: LSU pipe (decode), DMA and store-buffer drain share one
// DCCM access port. Normal priority is pipe > DMA > stbuf. Starvation counters
// open forced DMA-block or stbuf-drain windows, and decode stalls while one is open.
//
// Every cycle the grant outputs are derived combinationally from the requests
// and the registered state. When a grant and its request are both high in the
// same cycle, that requester owns the DCCM port for that cycle.

module lsu_dccm_arb #(
    parameter int DMA_STARVE_MAX   = 8,
    parameter int STBUF_STARVE_MAX = 16,
    parameter int DMA_BURST        = 4,
    parameter int CNT_W            = 5
) (
    input  logic       clk,
    input  logic       rst_l,
    input  logic       lsu_freeze_dc3,
    input  logic       lsu_p_valid,
    input  logic       dma_dccm_req,
    input  logic       stbuf_reqvld_any,
    input  logic       stbuf_full,
    output logic       lsu_pipe_gnt,
    output logic       dma_dccm_gnt,
    output logic       stbuf_gnt,
    output logic       lsu_pipe_stall,
    output logic [1:0] arb_state
);

    typedef enum logic [1:0] {
        NORMAL    = 2'd0,
        DMA_BLK   = 2'd1,
        STB_DRAIN = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DMA_MAX_C   = CNT_W'(DMA_STARVE_MAX);
    localparam logic [CNT_W-1:0] STB_MAX_C   = CNT_W'(STBUF_STARVE_MAX);
    localparam logic [CNT_W-1:0] BURST_C     = CNT_W'(DMA_BURST);
    localparam logic [CNT_W-1:0] ONE_C       = CNT_W'(1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] dma_wait, dma_wait_nxt;
    logic [CNT_W-1:0] stb_wait, stb_wait_nxt;
    logic [CNT_W-1:0] burst, burst_nxt;
    logic             stb_seen, stb_seen_nxt;   // a drain grant already happened in this window
    logic             gnt_en;

    // Grants are suppressed while in reset or frozen.
    assign gnt_en = rst_l & ~lsu_freeze_dc3;

    // Zero-latency grant selection from the registered state.
    always_comb begin
        lsu_pipe_gnt = 1'b0;
        dma_dccm_gnt = 1'b0;
        stbuf_gnt    = 1'b0;
        if (gnt_en) begin
            case (state)
                NORMAL: begin
                    lsu_pipe_gnt = lsu_p_valid;
                    dma_dccm_gnt = dma_dccm_req & ~lsu_p_valid;
                    stbuf_gnt    = stbuf_reqvld_any & ~lsu_p_valid & ~dma_dccm_req;
                end
                DMA_BLK: begin
                    dma_dccm_gnt = dma_dccm_req;
                    stbuf_gnt    = stbuf_reqvld_any & ~dma_dccm_req;
                end
                STB_DRAIN: begin
                    stbuf_gnt    = stbuf_reqvld_any;
                    dma_dccm_gnt = dma_dccm_req & ~stbuf_reqvld_any;
                end
                default: ;
            endcase
        end
    end

    // Next state, starvation counters and burst budget; everything holds when frozen.
    always_comb begin
        state_nxt    = state;
        dma_wait_nxt = dma_wait;
        stb_wait_nxt = stb_wait;
        burst_nxt    = burst;
        stb_seen_nxt = stb_seen;
        if (!lsu_freeze_dc3) begin
            if (dma_dccm_req && !dma_dccm_gnt)
                dma_wait_nxt = (dma_wait == DMA_MAX_C) ? dma_wait : dma_wait + ONE_C;
            else
                dma_wait_nxt = '0;
            if (stbuf_reqvld_any && !stbuf_gnt)
                stb_wait_nxt = (stb_wait == STB_MAX_C) ? stb_wait : stb_wait + ONE_C;
            else
                stb_wait_nxt = '0;

            case (state)
                NORMAL: begin
                    // A full store buffer outranks DMA starvation; DMA keeps counting meanwhile.
                    if (stbuf_full && stbuf_reqvld_any) begin
                        state_nxt    = STB_DRAIN;
                        stb_wait_nxt = '0;
                        stb_seen_nxt = 1'b0;
                    end else if (dma_wait == DMA_MAX_C && dma_dccm_req) begin
                        state_nxt    = DMA_BLK;
                        dma_wait_nxt = '0;
                        burst_nxt    = BURST_C;
                    end else if (stb_wait == STB_MAX_C && stbuf_reqvld_any) begin
                        state_nxt    = STB_DRAIN;
                        stb_wait_nxt = '0;
                        stb_seen_nxt = 1'b0;
                    end
                end
                DMA_BLK: begin
                    if (dma_dccm_gnt)
                        burst_nxt = burst - ONE_C;
                    if (!dma_dccm_req || (dma_dccm_gnt && burst == ONE_C)) begin
                        state_nxt    = NORMAL;
                        dma_wait_nxt = '0;
                    end
                end
                STB_DRAIN: begin
                    if (stbuf_gnt)
                        stb_seen_nxt = 1'b1;
                    // The current cycle's grant counts toward "drained at least once".
                    if (!stbuf_reqvld_any || (!stbuf_full && (stb_seen || stbuf_gnt))) begin
                        state_nxt    = NORMAL;
                        stb_wait_nxt = '0;
                    end
                end
                default: state_nxt = NORMAL;
            endcase
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state    <= NORMAL;
            dma_wait <= '0;
            stb_wait <= '0;
            burst    <= '0;
            stb_seen <= 1'b0;
        end else begin
            state    <= state_nxt;
            dma_wait <= dma_wait_nxt;
            stb_wait <= stb_wait_nxt;
            burst    <= burst_nxt;
            stb_seen <= stb_seen_nxt;
        end
    end

    // Stall comes straight from the state flop, so it only moves at clock edges.
    assign lsu_pipe_stall = (state != NORMAL);
    assign arb_state      = state;

    a_gnt_onehot0: assert property (@(posedge clk)
        $onehot0({lsu_pipe_gnt, dma_dccm_gnt, stbuf_gnt}));
    a_no_gnt_frozen: assert property (@(posedge clk)
        lsu_freeze_dc3 |-> !(lsu_pipe_gnt | dma_dccm_gnt | stbuf_gnt));
    a_no_pipe_when_stalled: assert property (@(posedge clk)
        lsu_pipe_stall |-> !lsu_pipe_gnt);

endmodule
